hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 32, PC/target width.
- REG_AW, 5, register index width.
- LOAD_LAT, 1, load-use bubble cycles (legal 1..8).
- MDU_LAT, 4, multiply/divide busy cycles (legal 2..15).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- rs_id, rt_id, in, REG_AW, ID source indices.
- rs_used, rt_used, in, 1, ID instruction reads rs/rt.
- rd_exe, in, REG_AW, EXE destination.
- exe_wen, exe_load, in, 1, EXE writes rd; EXE is a load.
- rd_mem, in, REG_AW, MEM destination.
- mem_wen, in, 1, MEM writes rd.
- mdu_start, in, 1, EXE holds a multi-cycle MDU op this cycle.
- br_taken, in, 1, ID branch/jump resolved taken.
- br_target, in, DATA_W, redirect address.
- pc_write, if_id_write, id_exe_write, out, 1, stage register enables.
- if_id_flush, id_exe_flush, out, 1, insert bubble.
- pc_src, out, 1, select pc_target.
- pc_target, out, DATA_W, redirect address.
- fwd_a, fwd_b, out, 2, 00 regfile / 01 EXE / 10 MEM for rs/rt.
- mdu_busy, out, 1, MDU stall active.
- stall_count, out, 32, saturating stall-cycle counter.

Function
REQ-003 Outputs SHALL be combinational from FSM state and inputs; state, counter and stall_count SHALL update on the rising clk edge.
REQ-004 FSM states SHALL be RUN, LD_STALL and MDU_WAIT, with a 4-bit down-counter cnt.
REQ-005 Load-use hazard (luh) SHALL be exe_load & exe_wen & rd_exe!=0 & ((rs_used & rs_id==rd_exe) | (rt_used & rt_id==rd_exe)).
REQ-006 RUN with no event SHALL drive pc_write=if_id_write=id_exe_write=1, flushes=0, pc_src=0, pc_target=0, mdu_busy=0.
REQ-007 Priority in RUN SHALL be mdu_start > luh > br_taken.
REQ-008 RUN & mdu_start SHALL drive pc_write=if_id_write=id_exe_write=0 and mdu_busy=1, then enter MDU_WAIT with cnt=MDU_LAT-2.
REQ-009 MDU_WAIT SHALL hold the same outputs as REQ-008 and decrement cnt; at cnt==0 it SHALL return to RUN; MDU stall is exactly MDU_LAT cycles.
REQ-010 RUN & luh SHALL drive pc_write=if_id_write=0 and id_exe_flush=1; if LOAD_LAT>1 it SHALL enter LD_STALL with cnt=LOAD_LAT-2, else remain in RUN.
REQ-011 LD_STALL SHALL repeat the REQ-010 outputs and decrement cnt; at cnt==0 it SHALL return to RUN; the bubble is exactly LOAD_LAT cycles.
REQ-012 RUN & br_taken without higher-priority events SHALL drive pc_src=1, pc_target=br_target, if_id_flush=1, pc_write=1.
REQ-013 br_taken SHALL be ignored outside RUN; the held ID branch is re-evaluated on return.
REQ-014 fwd_a SHALL be 01 if exe_wen & !exe_load & rd_exe!=0 & rd_exe==rs_id, else 10 if mem_wen & rd_mem!=0 & rd_mem==rs_id, else 00; fwd_b SHALL be the same using rt_id.
REQ-015 stall_count SHALL increment each cycle pc_write==0 and saturate at 32'hFFFF_FFFF.

Reset
REQ-016 Asynchronous assertion (reset==0) SHALL force RUN, cnt=0 and stall_count=0 immediately, including mid-stall; outputs then follow REQ-006 or the current inputs.
REQ-017 The first rising edge after deassertion SHALL evaluate normally.

Configuration
REQ-018 With macro HAZARD_CTRL_FWD_EN defined, forwarding SHALL follow REQ-014.
REQ-019 Without HAZARD_CTRL_FWD_EN, fwd_a and fwd_b SHALL be 00, and any used-source match against an EXE or MEM writer (rd!=0) SHALL stall as in REQ-010, re-evaluated every cycle without entering LD_STALL.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- LOAD_LAT=3, exe_load=1, rd_exe=8, rs_id=8, rs_used=1 -> pc_write=0 for exactly 3 cycles, id_exe_flush=1 each, stall_count=3.
- MDU_LAT=4, mdu_start pulse with br_taken=1 simultaneously -> 4 cycles mdu_busy=1, no redirect; redirect in cycle 5 with pc_target=br_target.
- rd_exe=rd_mem=5, exe_wen=mem_wen=1, rs_id=5, FWD_EN defined -> fwd_a=01; exe_wen=0 -> fwd_a=10; rd=0 -> fwd_a=00.
- Same case without FWD_EN -> pc_write=0 while the match persists, fwd_a=00.
- reset driven low mid-MDU_WAIT (cnt=2) -> immediately mdu_busy=0, pc_write=1, stall_count=0.
- stall_count preloaded near max with a continuous stall -> stall_count holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard unit covering load-use bubbles, MDU busy stalls,
//            branch redirects, operand forwarding select and a stall counter.
//            Forwarding is enabled by defining HAZARD_CTRL_FWD_EN.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic [REG_AW-1:0] rd_exe,
    input  logic              exe_wen,
    input  logic              exe_load,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              mem_wen,
    input  logic              mdu_start,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_target,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_exe_write,
    output logic              if_id_flush,
    output logic              id_exe_flush,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mdu_busy,
    output logic [31:0]       stall_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    // Counter preloads: the cycle spent in RUN already counts as the first stall cycle.
    localparam logic [3:0] c_MDU_CNT = 4'(MDU_LAT - 2);
    localparam logic [3:0] c_LD_CNT  = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_stall_count;
    logic        w_luh;
    logic        w_raw;

    assign w_luh = exe_load & exe_wen & (rd_exe != '0) &
                   ((rs_used & (rs_id == rd_exe)) | (rt_used & (rt_id == rd_exe)));

`ifdef HAZARD_CTRL_FWD_EN
    assign w_raw = 1'b0;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (exe_wen & ~exe_load & (rd_exe != '0) & (rd_exe == rs_id))
            fwd_a = 2'b01;
        else if (mem_wen & (rd_mem != '0) & (rd_mem == rs_id))
            fwd_a = 2'b10;
        if (exe_wen & ~exe_load & (rd_exe != '0) & (rd_exe == rt_id))
            fwd_b = 2'b01;
        else if (mem_wen & (rd_mem != '0) & (rd_mem == rt_id))
            fwd_b = 2'b10;
    end
`else
    // No bypass paths: any in-flight writer of a used source holds ID until it retires.
    assign w_raw = (rs_used & ((exe_wen & (rd_exe != '0) & (rd_exe == rs_id)) |
                               (mem_wen & (rd_mem != '0) & (rd_mem == rs_id)))) |
                   (rt_used & ((exe_wen & (rd_exe != '0) & (rd_exe == rt_id)) |
                               (mem_wen & (rd_mem != '0) & (rd_mem == rt_id))));
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_cnt         <= 4'd0;
            r_stall_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!pc_write && (r_stall_count != 32'hFFFF_FFFF))
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_exe_write = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        pc_src       = 1'b0;
        pc_target    = '0;
        mdu_busy     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mdu_start) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_exe_write = 1'b0;
                    mdu_busy     = 1'b1;
                    w_state_nxt  = ST_MDU_WAIT;
                    w_cnt_nxt    = c_MDU_CNT;
                end else if (w_luh || w_raw) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_exe_flush = 1'b1;
                    if (w_luh && (LOAD_LAT > 1)) begin
                        w_state_nxt = ST_LD_STALL;
                        w_cnt_nxt   = c_LD_CNT;
                    end
                end else if (br_taken) begin
                    pc_src      = 1'b1;
                    pc_target   = br_target;
                    if_id_flush = 1'b1;
                end
            end
            ST_LD_STALL: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_exe_flush = 1'b1;
                if (r_cnt == 4'd0) w_state_nxt = ST_RUN;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            ST_MDU_WAIT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_exe_write = 1'b0;
                mdu_busy     = 1'b1;
                if (r_cnt == 4'd0) w_state_nxt = ST_RUN;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl (LOAD_LAT=3, MDU_LAT=4).
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 3;
    localparam int MDU_LAT  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [REG_AW-1:0] rs_id = '0, rt_id = '0, rd_exe = '0, rd_mem = '0;
    logic              rs_used = 1'b0, rt_used = 1'b0;
    logic              exe_wen = 1'b0, exe_load = 1'b0, mem_wen = 1'b0;
    logic              mdu_start = 1'b0, br_taken = 1'b0;
    logic [DATA_W-1:0] br_target = '0;
    logic              pc_write, if_id_write, id_exe_write, if_id_flush, id_exe_flush;
    logic              pc_src, mdu_busy;
    logic [DATA_W-1:0] pc_target;
    logic [1:0]        fwd_a, fwd_b;
    logic [31:0]       stall_count;

    int tests = 0;
    int fails = 0;

    hazard_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
        .rd_exe(rd_exe), .exe_wen(exe_wen), .exe_load(exe_load),
        .rd_mem(rd_mem), .mem_wen(mem_wen),
        .mdu_start(mdu_start), .br_taken(br_taken), .br_target(br_target),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_exe_write(id_exe_write),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .pc_src(pc_src), .pc_target(pc_target),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stalls are tracked as "cycles still owed" rather than FSM states.
    int          m_mdu_left = 0;
    int          m_ld_left  = 0;
    logic [31:0] m_cnt = 32'd0;
    logic        m_pre_en = 1'b0;
    logic [31:0] m_pre_val = 32'd0;

    logic        e_pcw, e_ifw, e_idw, e_iff, e_idf, e_src, e_busy, hz_ld, hz_raw;
    logic [31:0] e_tgt, e_cnt;
    logic [1:0]  e_fa, e_fb;

    function automatic logic writer_hit(input logic [REG_AW-1:0] r, input logic ew,
                                        input logic [REG_AW-1:0] re, input logic mw,
                                        input logic [REG_AW-1:0] rm);
        return (ew && re != 0 && re == r) || (mw && rm != 0 && rm == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r);
        if (exe_wen && !exe_load && rd_exe != 0 && rd_exe == r) return 2'b01;
        if (mem_wen && rd_mem != 0 && rd_mem == r)              return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        e_pcw = 1'b1; e_ifw = 1'b1; e_idw = 1'b1; e_iff = 1'b0; e_idf = 1'b0;
        e_src = 1'b0; e_busy = 1'b0; e_tgt = 32'd0;
        e_cnt = m_pre_en ? m_pre_val : m_cnt;
        hz_ld = exe_load && exe_wen && rd_exe != 0 &&
                ((rs_used && rs_id == rd_exe) || (rt_used && rt_id == rd_exe));
`ifdef HAZARD_CTRL_FWD_EN
        hz_raw = 1'b0;
        e_fa   = fwd_sel(rs_id);
        e_fb   = fwd_sel(rt_id);
`else
        hz_raw = (rs_used && writer_hit(rs_id, exe_wen, rd_exe, mem_wen, rd_mem)) ||
                 (rt_used && writer_hit(rt_id, exe_wen, rd_exe, mem_wen, rd_mem));
        e_fa   = 2'b00;
        e_fb   = 2'b00;
`endif
        if (m_mdu_left > 0 || (m_ld_left == 0 && mdu_start)) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_idw = 1'b0; e_busy = 1'b1;
        end else if (m_ld_left > 0 || hz_ld || hz_raw) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
        end else if (br_taken) begin
            e_src = 1'b1; e_tgt = br_target; e_iff = 1'b1;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mdu_left <= 0;
            m_ld_left  <= 0;
            m_cnt      <= 32'd0;
        end else begin
            m_cnt <= (!e_pcw && e_cnt != 32'hFFFF_FFFF) ? e_cnt + 32'd1 : e_cnt;
            if (m_mdu_left > 0)     m_mdu_left <= m_mdu_left - 1;
            else if (m_ld_left > 0) m_ld_left  <= m_ld_left - 1;
            else if (mdu_start)     m_mdu_left <= MDU_LAT - 1;
            else if (hz_ld)         m_ld_left  <= LOAD_LAT - 1;
        end
    end

    always @(negedge clk) begin
        chk("pc_write",     {31'd0, pc_write},     {31'd0, e_pcw});
        chk("if_id_write",  {31'd0, if_id_write},  {31'd0, e_ifw});
        chk("id_exe_write", {31'd0, id_exe_write}, {31'd0, e_idw});
        chk("if_id_flush",  {31'd0, if_id_flush},  {31'd0, e_iff});
        chk("id_exe_flush", {31'd0, id_exe_flush}, {31'd0, e_idf});
        chk("pc_src",       {31'd0, pc_src},       {31'd0, e_src});
        chk("pc_target",    pc_target,             e_tgt);
        chk("mdu_busy",     {31'd0, mdu_busy},     {31'd0, e_busy});
        chk("fwd_a",        {30'd0, fwd_a},        {30'd0, e_fa});
        chk("fwd_b",        {30'd0, fwd_b},        {30'd0, e_fb});
        chk("stall_count",  stall_count,           e_cnt);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_id = '0; rt_id = '0; rd_exe = '0; rd_mem = '0;
        rs_used = 1'b0; rt_used = 1'b0; exe_wen = 1'b0; exe_load = 1'b0;
        mem_wen = 1'b0; mdu_start = 1'b0; br_taken = 1'b0; br_target = '0;
    endtask

    initial begin
        #2;
        chk("rst_stall_count", stall_count, 32'd0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        step(2);
        reset = 1'b1;
        step(1);

        // Load-use: one load in EXE, bubble lasts LOAD_LAT cycles.
        exe_load = 1'b1; exe_wen = 1'b1; rd_exe = 5'd8; rs_id = 5'd8; rs_used = 1'b1;
        #1;
        chk("ld_c1_pcw", {31'd0, pc_write}, 32'd0);
        chk("ld_c1_flush", {31'd0, id_exe_flush}, 32'd1);
        step(1);
        clear_inputs();
        #1;
        chk("ld_c2_pcw", {31'd0, pc_write}, 32'd0);
        chk("ld_c2_flush", {31'd0, id_exe_flush}, 32'd1);
        step(1);
        chk("ld_c3_pcw", {31'd0, pc_write}, 32'd0);
        step(1);
        chk("ld_done_pcw", {31'd0, pc_write}, 32'd1);
        chk("ld_stall_count", stall_count, 32'd3);

        // MDU start with simultaneous branch: branch waits out the MDU stall.
        mdu_start = 1'b1; br_taken = 1'b1; br_target = 32'hDEAD_BEE0;
        #1;
        chk("mdu_c1_busy", {31'd0, mdu_busy}, 32'd1);
        chk("mdu_c1_src", {31'd0, pc_src}, 32'd0);
        step(1);
        mdu_start = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            #1;
            chk("mdu_cN_busy", {31'd0, mdu_busy}, 32'd1);
            chk("mdu_cN_src", {31'd0, pc_src}, 32'd0);
            step(1);
        end
        chk("br_c5_src", {31'd0, pc_src}, 32'd1);
        chk("br_c5_target", pc_target, 32'hDEAD_BEE0);
        chk("br_c5_flush", {31'd0, if_id_flush}, 32'd1);
        chk("mdu_stall_count", stall_count, 32'd7);
        clear_inputs();
        step(1);

        // EXE/MEM both writing r5, ID reads r5.
        rd_exe = 5'd5; rd_mem = 5'd5; exe_wen = 1'b1; mem_wen = 1'b1; rs_id = 5'd5; rs_used = 1'b1;
        #1;
`ifdef HAZARD_CTRL_FWD_EN
        chk("fwd_exe", {30'd0, fwd_a}, 32'd1);
        chk("fwd_exe_pcw", {31'd0, pc_write}, 32'd1);
        step(1);
        exe_wen = 1'b0;
        #1;
        chk("fwd_mem", {30'd0, fwd_a}, 32'd2);
        step(1);
        rd_exe = 5'd0; rd_mem = 5'd0; exe_wen = 1'b1;
        #1;
        chk("fwd_r0", {30'd0, fwd_a}, 32'd0);
`else
        chk("nofwd_fa", {30'd0, fwd_a}, 32'd0);
        chk("nofwd_pcw", {31'd0, pc_write}, 32'd0);
        step(2);
        chk("nofwd_persist_pcw", {31'd0, pc_write}, 32'd0);
        exe_wen = 1'b0;
        #1;
        chk("nofwd_mem_pcw", {31'd0, pc_write}, 32'd0);
        step(1);
        rd_exe = 5'd0; rd_mem = 5'd0; exe_wen = 1'b1;
        #1;
        chk("nofwd_r0_pcw", {31'd0, pc_write}, 32'd1);
        chk("nofwd_r0_fa", {30'd0, fwd_a}, 32'd0);
`endif
        step(1);
        clear_inputs();
        step(1);

        // Asynchronous reset while MDU_WAIT still owes cycles.
        mdu_start = 1'b1;
        step(1);
        mdu_start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, mdu_busy}, 32'd0);
        chk("arst_pcw", {31'd0, pc_write}, 32'd1);
        chk("arst_stall_count", stall_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(2);

        // Saturation: preload counter, hold a load-use hazard continuously.
        exe_load = 1'b1; exe_wen = 1'b1; rd_exe = 5'd3; rt_id = 5'd3; rt_used = 1'b1;
        dut.r_stall_count = 32'hFFFF_FFFD;
        m_pre_val = 32'hFFFF_FFFD;
        m_pre_en  = 1'b1;
        step(1);
        m_pre_en = 1'b0;
        step(5);
        chk("sat_stall_count", stall_count, 32'hFFFF_FFFF);
        chk("sat_pcw", {31'd0, pc_write}, 32'd0);
        clear_inputs();
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
